// File: rtl/pl_io_responder.sv
// Memory-mapped I/O responder for the MEM-stage load/store port: input ports with
// synchronizer, debounce and sticky change flags, plus three registered output ports.
module pl_io_responder #(
   parameter int DEBOUNCE = 4,
   parameter int CNT_W    = 8
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   input  logic        re,
   input  logic [31:0] raw_in0,
   input  logic [31:0] raw_in1,
   output logic [31:0] rdata,
   output logic        io_hit,
   output logic [31:0] out_port0,
   output logic [31:0] out_port1,
   output logic [31:0] out_port2,
   output logic        irq
);

   localparam logic [4:0] OFF_IN0    = 5'd0;
   localparam logic [4:0] OFF_IN1    = 5'd1;
   localparam logic [4:0] OFF_STATUS = 5'd2;
   localparam logic [4:0] OFF_OUT0   = 5'd16;
   localparam logic [4:0] OFF_OUT1   = 5'd17;
   localparam logic [4:0] OFF_OUT2   = 5'd18;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

   logic [4:0]             offset;
   logic                   rd_hit;
   logic                   wr_hit;
   logic                   addr_unused;
   logic [1:0][31:0]       raw;
   logic [1:0][31:0]       sync_p0;
   logic [1:0][31:0]       sync_p1;
   logic [1:0][31:0]       cand;
   logic [1:0][31:0]       stable;
   logic [1:0][CNT_W-1:0]  cnt;
   logic [1:0]             chg;
   logic [1:0]             chg_set;
   logic [1:0]             chg_clr;

   function automatic logic cnt_saturated(input logic [CNT_W-1:0] c);
      return c >= CNT_MAX;
   endfunction

   assign offset      = addr[6:2];
   assign addr_unused = ^addr[1:0];
   assign io_hit      = (addr[31:8] == 24'd0) && addr[7];
   assign rd_hit      = re && io_hit;
   assign wr_hit      = we && io_hit;
   assign raw[0]      = raw_in0;
   assign raw[1]      = raw_in1;

   always_comb begin
      rdata = '0;
      if (rd_hit) begin
         case (offset)
            OFF_IN0:    rdata = stable[0];
            OFF_IN1:    rdata = stable[1];
            OFF_STATUS: rdata = {30'b0, chg};
            OFF_OUT0:   rdata = out_port0;
            OFF_OUT1:   rdata = out_port1;
            OFF_OUT2:   rdata = out_port2;
            default:    rdata = '0;
         endcase
      end
   end

   // a flag is raised on the edge the debounced value is accepted and differs
   always_comb begin
      chg_set = '0;
      chg_clr = '0;
      for (int n = 0; n < 2; n++) begin
         chg_set[n] = (sync_p1[n] == cand[n]) && cnt_saturated(cnt[n]) &&
                      (cand[n] != stable[n]);
         chg_clr[n] = (rd_hit && (offset == 5'(n))) ||
                      (wr_hit && (offset == OFF_STATUS) && wdata[n]);
      end
   end

   // synchronizer stages feed the candidate/counter debounce filter
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
         cand    <= '0;
         cnt     <= '0;
         stable  <= '0;
      end else begin
         for (int n = 0; n < 2; n++) begin
            sync_p0[n] <= raw[n];
            sync_p1[n] <= sync_p0[n];
            if (sync_p1[n] != cand[n]) begin
               cand[n] <= sync_p1[n];
               cnt[n]  <= '0;
            end else if (!cnt_saturated(cnt[n])) begin
               cnt[n] <= cnt[n] + CNT_W'(1);
            end else begin
               stable[n] <= cand[n];
            end
         end
      end
   end

   // set wins over a simultaneous clear
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         chg <= '0;
         irq <= 1'b0;
      end else begin
         chg <= chg_set | (chg & ~chg_clr);
         irq <= |chg;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         out_port0 <= '0;
         out_port1 <= '0;
         out_port2 <= '0;
      end else if (wr_hit) begin
         case (offset)
            OFF_OUT0: out_port0 <= wdata;
            OFF_OUT1: out_port1 <= wdata;
            OFF_OUT2: out_port2 <= wdata;
            default: ;
         endcase
      end
   end

endmodule
